// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_pkg
// Description : Shared types and compare helper for the comparator arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

   localparam int CMP_XLEN = 32;
   localparam int CMP_ID_W = 2;

   typedef struct packed {
      logic [CMP_XLEN-1:0] a;
      logic [CMP_XLEN-1:0] b;
      logic                sgn;
   } cmp_req_t;

   typedef struct packed {
      logic [CMP_ID_W-1:0] id;
      logic                less;
      logic                equal;
   } cmp_rsp_t;

   // Borrow out of a one-bit-extended subtraction gives a < b for both signednesses.
   function automatic logic cmp_less(input cmp_req_t r);
      logic [CMP_XLEN:0] d;
      d = {r.sgn & r.a[CMP_XLEN-1], r.a} - {r.sgn & r.b[CMP_XLEN-1], r.b};
      return d[CMP_XLEN];
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Round-robin arbiter; pointer advances past the winner on en.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb
   import cmp_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic                 en,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int c_idx_w = $clog2(N);

   logic [c_idx_w-1:0] r_ptr;
   logic [c_idx_w:0]   w_pos;
   logic [c_idx_w-1:0] w_idx;
   logic               w_found;

   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = {1'b0, r_ptr} + (c_idx_w+1)'(k);
         if (w_pos >= (c_idx_w+1)'(N)) begin
            w_pos = w_pos - (c_idx_w+1)'(N);
         end
         if (!w_found && req[w_pos[c_idx_w-1:0]]) begin
            w_found = 1'b1;
            w_idx   = w_pos[c_idx_w-1:0];
         end
      end
   end

   assign grant     = w_found ? (N'(1) << w_idx) : '0;
   assign grant_idx = w_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (en && w_found) begin
         r_ptr <= (w_idx == c_idx_w'(N-1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_arbiter
// Description : One shared 32-bit comparator, round-robin among N requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int XLEN  = CMP_XLEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*XLEN-1:0]    req_a,
   input  logic [N_REQ*XLEN-1:0]    req_b,
   input  logic [N_REQ-1:0]         req_sgn,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(N_REQ)-1:0] rsp_id,
   output logic                     rsp_less,
   output logic                     rsp_equal
);

   localparam int c_id_w = $clog2(N_REQ);

   logic              w_accept_en;
   logic              w_accept;
   logic [N_REQ-1:0]  w_grant;
   logic [c_id_w-1:0] w_grant_idx;
   cmp_req_t          w_sel;
   cmp_rsp_t          r_rsp;
   logic              r_rsp_valid;

   // Slot is free when empty or being drained this cycle; reset blocks all handshakes.
   assign w_accept_en = !rst && (!r_rsp_valid || rsp_ready);

   rr_arb #(
      .N         (N_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .en        (w_accept_en),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

   assign req_ready = w_grant & {N_REQ{w_accept_en}};
   assign w_accept  = |req_ready;

   always_comb begin
      w_sel     = '0;
      w_sel.a   = req_a[w_grant_idx*XLEN +: XLEN];
      w_sel.b   = req_b[w_grant_idx*XLEN +: XLEN];
      w_sel.sgn = req_sgn[w_grant_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else if (w_accept) begin
         r_rsp_valid <= 1'b1;
         r_rsp.id    <= CMP_ID_W'(w_grant_idx);
         r_rsp.less  <= cmp_less(w_sel);
         r_rsp.equal <= (w_sel.a == w_sel.b);
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp.id[c_id_w-1:0];
   assign rsp_less  = r_rsp.less;
   assign rsp_equal = r_rsp.equal;

   generate
      if (c_id_w < CMP_ID_W) begin : g_id_trim
         logic w_unused_id;
         assign w_unused_id = ^r_rsp.id[CMP_ID_W-1:c_id_w];
      end
   endgenerate

endmodule
`default_nettype wire
